// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default sizes.
package uart_pkg;

  localparam int unsigned NUM_REQ_DEF     = 4;
  localparam int unsigned WORD_LENGTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin search: first set bit of req at or above ptr, wrapping past NUM_REQ-1 to 0.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = ptr;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand = IDX_W'((int'(ptr) + k) % int'(NUM_REQ));
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_REQ byte streams onto one UART transmitter, holding the
// transmitter for a whole packet (until req_last) once a requester wins.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
  parameter int unsigned WORD_LENGTH    = WORD_LENGTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                           clk_glb,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           tx_ready,
  output logic                           tx_start,
  output logic [WORD_LENGTH-1:0]         tx_data,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic                           err_timeout
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  arb_state_e             state, state_d;
  logic [WORD_LENGTH-1:0] tx_data_d;
  logic [ID_W-1:0]        grant_d;
  logic [ID_W-1:0]        rr_ptr, rr_ptr_d;
  logic                   lock, lock_d;
  logic                   last_q, last_d;
  logic [CNT_W-1:0]       tmo_cnt, tmo_d;
  logic                   tx_start_d, busy_d, err_d;

  logic [WORD_LENGTH-1:0] req_byte [NUM_REQ];
  logic [NUM_REQ-1:0]     req_mask;
  logic                   pick_found;
  logic [ID_W-1:0]        pick_idx;
  logic [ID_W-1:0]        next_ptr;

  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_byte
    assign req_byte[g] = req_data[g*WORD_LENGTH +: WORD_LENGTH];
  end

  // While a packet lock is held only the owner (grant_id) may be selected.
  assign req_mask = lock ? (req_valid & (NUM_REQ'(1) << grant_id)) : req_valid;
  assign next_ptr = (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr_pick (
    .req   (req_mask),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  // Next-state and next-register logic; req_ready is the only combinational output.
  always_comb begin
    state_d   = state;
    tx_data_d = tx_data;
    grant_d   = grant_id;
    rr_ptr_d  = rr_ptr;
    lock_d    = lock;
    last_d    = last_q;
    tmo_d     = tmo_cnt;
    err_d     = 1'b0;
    req_ready = '0;

    unique case (state)
      IDLE: begin
        if (pick_found) begin
          req_ready = NUM_REQ'(1) << pick_idx;
          tx_data_d = req_byte[pick_idx];
          last_d    = req_last[pick_idx];
          grant_d   = pick_idx;
          lock_d    = 1'b1;
          tmo_d     = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d = tmo_cnt + CNT_W'(1);
        if (!tx_ready) begin
          state_d = WAIT_DONE;
        end else if (tmo_cnt == CNT_LAST) begin
          // Transmitter never took the byte: drop it and release the packet.
          err_d    = 1'b1;
          lock_d   = 1'b0;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          state_d = IDLE;
          if (last_q) begin
            lock_d   = 1'b0;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_start_d = (state_d == ISSUE);
    busy_d     = (state_d != IDLE) || lock_d;
  end

  always_ff @(posedge clk_glb or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      rr_ptr      <= '0;
      lock        <= 1'b0;
      last_q      <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      state       <= state_d;
      tx_start    <= tx_start_d;
      tx_data     <= tx_data_d;
      grant_id    <= grant_d;
      busy        <= busy_d;
      err_timeout <= err_d;
      rr_ptr      <= rr_ptr_d;
      lock        <= lock_d;
      last_q      <= last_d;
      tmo_cnt     <= tmo_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: requester queues feed the arbiter, a transmitter model
// checks each granted byte against a scoreboard of expected (owner, byte) pairs.
module tb_uart_tx_arbiter;

  localparam int FRAME = 10;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic            clk_glb = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      req_valid = '0;
  logic [3:0][7:0] req_bytes = '0;
  logic [3:0]      req_last = '0;
  logic [3:0]      req_ready;
  logic            tx_ready = 1'b1;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic [1:0]      grant_id;
  logic            busy;
  logic            err_timeout;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  logic [8:0] rmem [4][32];
  logic [4:0] rhead [4] = '{default: '0};
  logic [4:0] rtail [4] = '{default: '0};
  logic [3:0] fire;
  logic [1:0] k;

  logic tx_hang = 1'b0;
  int   rst_epoch = 0;
  int   cyc = 0;
  int   ready_cnt [4] = '{default: 0};
  int   err_seen = 0;
  int   err_cyc = 0;
  int   issue_cyc = 0;
  logic start_prev = 1'b0;

  always #5 clk_glb = ~clk_glb;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .WORD_LENGTH    (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_glb     (clk_glb),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_bytes),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_ready    (tx_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  // Requester driver: pop on handshake, present queue heads, scramble idle data.
  always begin
    @(negedge clk_glb);
    fire = rst_n ? (req_valid & req_ready) : 4'b0;
    @(posedge clk_glb);
    #1;
    for (bit [2:0] i = 3'd0; i < 3'd4; i++) begin
      k = i[1:0];
      if (fire[k]) rhead[k] = rhead[k] + 5'd1;
      if (rhead[k] != rtail[k]) begin
        req_valid[k] = 1'b1;
        {req_last[k], req_bytes[k]} = rmem[k][rhead[k]];
      end else begin
        req_valid[k] = 1'b0;
        req_last[k]  = 1'b0;
        req_bytes[k] = 8'($urandom);
      end
    end
  end

  always @(posedge clk_glb) cyc <= cyc + 1;

  always @(negedge clk_glb) begin
    for (bit [2:0] i = 3'd0; i < 3'd4; i++)
      ready_cnt[i[1:0]] <= ready_cnt[i[1:0]] + ((rst_n && req_ready[i[1:0]]) ? 1 : 0);
    if (tx_start && !start_prev) issue_cyc <= cyc;
    start_prev <= tx_start;
    if (err_timeout) begin
      err_seen <= err_seen + 1;
      err_cyc  <= cyc;
    end
  end

  task automatic load(input logic [1:0] id, input logic [7:0] d, input logic last);
    rmem[id][rtail[id]] = {last, d};
    rtail[id] = rtail[id] + 5'd1;
  endtask

  task automatic expect_byte(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Transmitter model: accepts a start, checks it against the scoreboard, runs a frame.
  task automatic tx_model();
    exp_t e;
    int d;
    int ep;
    forever begin
      @(negedge clk_glb);
      if (rst_n && !tx_hang && tx_start && tx_ready) begin
        ep = rst_epoch;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got id=%0d data=%02h, none expected", grant_id, tx_data);
          e.id = grant_id;
          e.data = tx_data;
        end else begin
          e = exp_q.pop_front();
          if (grant_id !== e.id || tx_data !== e.data) begin
            bad++;
            $display("FAIL sb_byte: got id=%0d data=%02h, exp id=%0d data=%02h",
                     grant_id, tx_data, e.id, e.data);
          end
        end
        d = $urandom_range(0, 2);
        repeat (d) begin
          @(negedge clk_glb);
          if (rst_epoch == ep) begin
            total++;
            if (tx_start !== 1'b1) begin
              bad++;
              $display("FAIL start_hold: tx_start=%b exp 1", tx_start);
            end
          end
        end
        @(posedge clk_glb);
        #1 tx_ready = 1'b0;
        @(negedge clk_glb);
        if (rst_epoch == ep) begin
          total++;
          if (tx_start !== 1'b1) begin
            bad++;
            $display("FAIL start_until_fall: tx_start=%b exp 1", tx_start);
          end
        end
        @(negedge clk_glb);
        if (rst_epoch == ep) begin
          total++;
          if (tx_start !== 1'b0) begin
            bad++;
            $display("FAIL start_drop: tx_start=%b exp 0", tx_start);
          end
        end
        repeat (FRAME) @(posedge clk_glb);
        #1;
        if (rst_epoch == ep) begin
          total++;
          if (tx_data !== e.data) begin
            bad++;
            $display("FAIL data_stable: tx_data=%02h exp %02h", tx_data, e.data);
          end
        end
        tx_ready = 1'b1;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || !tx_ready) && n < 400) begin
      @(negedge clk_glb);
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL drain_%s: pending=%0d busy=%b after %0d cycles", name, exp_q.size(), busy, n);
    end
  endtask

  task automatic wait_ready_cnt(input int idx, input int base, input string name);
    int n;
    n = 0;
    while (ready_cnt[idx[1:0]] == base && n < 60) begin
      @(negedge clk_glb);
      n++;
    end
    total++;
    if (n >= 60) begin
      bad++;
      $display("FAIL %s: req_ready[%0d] never seen within 60 cycles", name, idx);
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({tx_start, tx_data, grant_id, busy, err_timeout, req_ready} !== '0) begin
      bad++;
      $display("FAIL %s: start=%b data=%02h gid=%0d busy=%b err=%b ready=%b, exp all 0",
               name, tx_start, tx_data, grant_id, busy, err_timeout, req_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_glb);
    check_zero("reset_outputs");
    total++;
    if (tx_start !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: tx_start=%b busy=%b exp 0 0", tx_start, busy);
    end
    rst_n = 1'b1;
    @(negedge clk_glb);
  endtask

  task automatic test_contention();
    load(2'd0, 8'h10, 1'b1);
    load(2'd1, 8'h11, 1'b1);
    load(2'd2, 8'h12, 1'b1);
    load(2'd3, 8'h13, 1'b1);
    load(2'd0, 8'h14, 1'b1);
    expect_byte(2'd0, 8'h10);
    expect_byte(2'd1, 8'h11);
    expect_byte(2'd2, 8'h12);
    expect_byte(2'd3, 8'h13);
    expect_byte(2'd0, 8'h14);
    wait_drain("contention");
  endtask

  task automatic test_lock();
    int r1;
    r1 = ready_cnt[1];
    load(2'd1, 8'h1A, 1'b0);
    load(2'd0, 8'h0A, 1'b1);
    expect_byte(2'd1, 8'h1A);
    expect_byte(2'd1, 8'h1B);
    expect_byte(2'd1, 8'h1C);
    expect_byte(2'd0, 8'h0A);
    wait_ready_cnt(1, r1, "lock_first");
    repeat (30) @(negedge clk_glb);
    total++;
    if (busy !== 1'b1 || tx_start !== 1'b0) begin
      bad++;
      $display("FAIL lock_hold: busy=%b tx_start=%b exp 1 0", busy, tx_start);
    end
    load(2'd1, 8'h1B, 1'b0);
    load(2'd1, 8'h1C, 1'b1);
    wait_drain("lock");
  endtask

  task automatic test_single();
    int r2;
    r2 = ready_cnt[2];
    load(2'd2, 8'hA5, 1'b1);
    expect_byte(2'd2, 8'hA5);
    wait_drain("single");
    total++;
    if (ready_cnt[2] - r2 != 1) begin
      bad++;
      $display("FAIL single_ready: req_ready[2] high %0d cycles exp 1", ready_cnt[2] - r2);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL single_busy: busy=%b exp 0", busy);
    end
    load(2'd0, 8'h50, 1'b1);
    load(2'd3, 8'h53, 1'b1);
    expect_byte(2'd3, 8'h53);
    expect_byte(2'd0, 8'h50);
    wait_drain("single_rr");
  endtask

  task automatic test_wrap();
    load(2'd3, 8'hE3, 1'b1);
    expect_byte(2'd3, 8'hE3);
    wait_drain("wrap_owner");
    load(2'd0, 8'hE0, 1'b1);
    load(2'd3, 8'hF3, 1'b1);
    expect_byte(2'd0, 8'hE0);
    expect_byte(2'd3, 8'hF3);
    wait_drain("wrap");
  endtask

  task automatic test_timeout();
    int e0;
    int n;
    e0 = err_seen;
    tx_hang = 1'b1;
    load(2'd2, 8'h77, 1'b1);
    n = 0;
    while (err_seen == e0 && n < 80) begin
      @(negedge clk_glb);
      n++;
    end
    total++;
    if (n >= 80) begin
      bad++;
      $display("FAIL timeout_seen: no err_timeout within 80 cycles");
    end
    repeat (2) @(negedge clk_glb);
    total++;
    if (err_cyc - issue_cyc != 16) begin
      bad++;
      $display("FAIL timeout_delay: pulse %0d cycles after ISSUE exp 16", err_cyc - issue_cyc);
    end
    total++;
    if (err_seen - e0 != 1) begin
      bad++;
      $display("FAIL timeout_width: %0d pulse cycles exp 1", err_seen - e0);
    end
    total++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      bad++;
      $display("FAIL timeout_idle: busy=%b tx_start=%b exp 0 0", busy, tx_start);
    end
    tx_hang = 1'b0;
    load(2'd3, 8'h33, 1'b1);
    expect_byte(2'd3, 8'h33);
    wait_drain("timeout_next");
  endtask

  task automatic test_reset_mid();
    int r1;
    int n;
    r1 = ready_cnt[1];
    load(2'd1, 8'hB1, 1'b0);
    expect_byte(2'd1, 8'hB1);
    wait_ready_cnt(1, r1, "rst_mid_grant");
    repeat (6) @(negedge clk_glb);
    total++;
    if (tx_start !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_pre: tx_start=%b busy=%b tx_ready=%b exp 0 1 0",
               tx_start, busy, tx_ready);
    end
    #2;
    rst_epoch++;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid_outputs");
    @(negedge clk_glb);
    rst_n = 1'b1;
    n = 0;
    while (!tx_ready && n < 40) begin
      @(negedge clk_glb);
      n++;
    end
    load(2'd3, 8'hC3, 1'b1);
    load(2'd2, 8'hC2, 1'b1);
    expect_byte(2'd2, 8'hC2);
    expect_byte(2'd3, 8'hC3);
    wait_drain("rst_mid");
  endtask

  initial begin
    fork
      tx_model();
    join_none
    test_reset();
    test_contention();
    test_lock();
    test_single();
    test_wrap();
    test_timeout();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_empty: %0d bytes never transmitted exp 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
